// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/move sequencer.
// Holds the FSM state encoding, the op encoding and the datapath sizes.
package muldiv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned PROD_W     = 2 * XLEN;
    localparam int unsigned MULT_STEPS = 32;
    localparam int unsigned CNT_W      = $clog2(MULT_STEPS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIX   = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_MTHI  = 2'd2,
        OP_MTLO  = 2'd3
    } op_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between a requester and the multiply/move sequencer.
// The requester drives start/op/A/B; the sequencer returns status and HI/LO.
interface muldiv_sequencer_if;
    import muldiv_pkg::*;

    logic            start;
    op_e             op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] HI;
    logic [XLEN-1:0] LO;
    logic [1:0]      stateOut;

    modport master (
        output start, op, A, B,
        input  busy, done, HI, LO, stateOut
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, HI, LO, stateOut
    );

endinterface

// File: rtl/mult_engine.sv
// Shift-add multiply datapath: operand magnitudes, 64-bit accumulator and step counter.
// Sign is handled by multiplying magnitudes and negating the product once at the end.
module mult_engine
    import muldiv_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic              signed_i,
    input  logic              step_i,
    input  logic              negate_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [PROD_W-1:0] prod_o,
    output logic              last_step_o
);

    logic [PROD_W-1:0] mcand_q;
    logic [PROD_W-1:0] acc_q;
    logic [XLEN-1:0]   mplier_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sign_q;

    logic [XLEN-1:0]   a_mag_c;
    logic [XLEN-1:0]   b_mag_c;

    // 0x80000000 negates to itself, which read unsigned is exactly 2^31.
    always_comb begin
        a_mag_c = a_i;
        b_mag_c = b_i;
        if (signed_i && a_i[XLEN-1]) a_mag_c = ~a_i + XLEN'(1);
        if (signed_i && b_i[XLEN-1]) b_mag_c = ~b_i + XLEN'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
        end else if (load_i) begin
            mcand_q  <= PROD_W'(a_mag_c);
            mplier_q <= b_mag_c;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= signed_i & (a_i[XLEN-1] ^ b_i[XLEN-1]);
        end else if (step_i) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end else if (negate_i && sign_q) begin
            acc_q <= ~acc_q + PROD_W'(1);
        end
    end

    assign prod_o      = acc_q;
    assign last_step_o = (cnt_q == CNT_W'(MULT_STEPS - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO sequencer: FSM that runs the shift-add engine for MULT/MULTU and
// performs single-cycle MTHI/MTLO moves, owning the architectural HI/LO registers.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    muldiv_sequencer_if.slave  bus
);

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic              is_mul_c;
    logic              load_c;
    logic              step_c;
    logic              negate_c;
    logic [PROD_W-1:0] prod_c;
    logic              last_step_c;

    // Engine controls decode straight from the current state.
    always_comb begin
        is_mul_c = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
        load_c   = (state_q == ST_IDLE) && bus.start && is_mul_c;
        step_c   = (state_q == ST_RUN);
        negate_c = (state_q == ST_FIX);
    end

    mult_engine u_engine (
        .clock       (clock),
        .reset       (reset),
        .load_i      (load_c),
        .signed_i    (bus.op == OP_MULT),
        .step_i      (step_c),
        .negate_i    (negate_c),
        .a_i         (bus.A),
        .b_i         (bus.B),
        .prod_o      (prod_c),
        .last_step_o (last_step_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                state_q <= ST_RUN;
                                busy_q  <= 1'b1;
                            end
                            OP_MTHI: begin
                                hi_q   <= bus.A;
                                done_q <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_q   <= bus.A;
                                done_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (last_step_c) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    hi_q    <= prod_c[PROD_W-1:XLEN];
                    lo_q    <= prod_c[XLEN-1:0];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign bus.stateOut = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: table of multiplies plus hand-written
// sequences for moves, ignored starts while busy and mid-run reset.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int unsigned DONE_EDGES = 34;
    localparam int unsigned WAIT_LIMIT = 60;

    typedef struct {
        op_e         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    muldiv_sequencer_if bus ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Launch a multiply from IDLE and follow it to its done pulse.
    task automatic run_mult(input string name, input op_e op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        int   edges;
        logic hold_ok;
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.start = 1'b0;
        check({name, " E0 busy"}, 64'(bus.busy), 64'd1);
        check({name, " E0 state"}, 64'(bus.stateOut), 64'(ST_RUN));
        check({name, " E0 done"}, 64'(bus.done), 64'd0);
        edges   = 0;
        hold_ok = 1'b1;
        while (!bus.done && edges < WAIT_LIMIT) begin
            if (bus.HI !== exp_hi || bus.LO !== exp_lo || bus.busy !== 1'b1) hold_ok = 1'b0;
            tick();
            edges++;
        end
        check({name, " hold"}, 64'(hold_ok), 64'd1);
        check({name, " latency"}, 64'(edges), 64'(DONE_EDGES));
        check({name, " HI"}, 64'(bus.HI), 64'(hi));
        check({name, " LO"}, 64'(bus.LO), 64'(lo));
        check({name, " idle"}, {62'd0, bus.stateOut}, 64'(ST_IDLE));
        check({name, " busy low"}, 64'(bus.busy), 64'd0);
        exp_hi = hi;
        exp_lo = lo;
    endtask

    task automatic do_move(input string name, input op_e op, input logic [31:0] a);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        tick();
        bus.start = 1'b0;
        if (op == OP_MTHI) exp_hi = a;
        else exp_lo = a;
        check({name, " done"}, 64'(bus.done), 64'd1);
        check({name, " HI"}, 64'(bus.HI), 64'(exp_hi));
        check({name, " LO"}, 64'(bus.LO), 64'(exp_lo));
        check({name, " state"}, 64'(bus.stateOut), 64'(ST_IDLE));
    endtask

    vec_t vecs[10];

    initial begin
        int   edges;
        logic saw_done;

        vecs[0] = '{OP_MULT,  32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[3] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[4] = '{OP_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        vecs[5] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[6] = '{OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
        vecs[7] = '{OP_MULT,  32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000};
        vecs[8] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[9] = '{OP_MULTU, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF1};

        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.A     = '0;
        bus.B     = '0;
        exp_hi    = '0;
        exp_lo    = '0;
        tick();
        tick();
        check("reset HI", 64'(bus.HI), 64'd0);
        check("reset LO", 64'(bus.LO), 64'd0);
        check("reset state", 64'(bus.stateOut), 64'(ST_IDLE));
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        tick();

        // Idle with start low must hold everything.
        tick();
        check("idle hold done", 64'(bus.done), 64'd0);
        check("idle hold state", 64'(bus.stateOut), 64'(ST_IDLE));

        // Back-to-back moves: the second is issued in the first's done cycle.
        do_move("mthi", OP_MTHI, 32'hA5A5_5A5A);
        do_move("mtlo", OP_MTLO, 32'hCAFE_F00D);
        tick();
        check("move done drops", 64'(bus.done), 64'd0);

        // Each vector starts in the previous one's done cycle.
        for (int i = 0; i < 10; i++) begin
            run_mult($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        end
        tick();
        check("mult done drops", 64'(bus.done), 64'd0);

        // Start pulsed mid-run (as an MTHI) must be ignored.
        do_move("pre mthi", OP_MTHI, 32'h1234_5678);
        tick();
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.A     = 32'd2;
        bus.B     = 32'd3;
        tick();
        bus.start = 1'b0;
        edges     = 0;
        saw_done  = 1'b0;
        while (!bus.done && edges < WAIT_LIMIT) begin
            if (edges == 9) begin
                bus.start = 1'b1;
                bus.op    = OP_MTHI;
                bus.A     = 32'hDEAD_BEEF;
                bus.B     = 32'h0000_0100;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.HI !== 32'h1234_5678) saw_done = 1'b1;
            tick();
            edges++;
        end
        bus.start = 1'b0;
        check("ignored start HI held", 64'(saw_done), 64'd0);
        check("ignored start latency", 64'(edges), 64'(DONE_EDGES));
        check("ignored start HI", 64'(bus.HI), 64'd0);
        check("ignored start LO", 64'(bus.LO), 64'd6);
        tick();
        check("ignored start no redo", 64'(bus.busy), 64'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd6;

        // Reset in the middle of a multiply abandons it.
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.A     = 32'd7;
        bus.B     = 32'd9;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("pre-reset busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        #1;
        check("mid reset state", 64'(bus.stateOut), 64'(ST_IDLE));
        check("mid reset busy", 64'(bus.busy), 64'd0);
        check("mid reset HI", 64'(bus.HI), 64'd0);
        check("mid reset LO", 64'(bus.LO), 64'd0);
        check("mid reset done", 64'(bus.done), 64'd0);
        tick();
        reset    = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        check("no done after reset", 64'(saw_done), 64'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        run_mult("post reset", OP_MULT, 32'd7, 32'd9, 32'd0, 32'd63);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
